// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch stage: XLEN, the NOP encoding,
// the default instruction memory size and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned IMEM_SIZE_DEFAULT = 4096;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment: control inputs,
// instruction memory port, IF/ID register outputs and status.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            fetch_fault;
  logic [XLEN-1:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_instr,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_fault, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_instr,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_fault, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush-to-NOP controls.
// Priority: reset > flush > load > hold.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // pc is kept on flush; only the instruction and valid are squashed
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT FSM and fault detection.
// Define FETCH_PERF_CNT_EN to build the valid-fetch counter behind fetch_count.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int unsigned     IMEM_SIZE = IMEM_SIZE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [XLEN-1:0] LastWordAddr = XLEN'(IMEM_SIZE) - XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            load, flush;
  logic            pc_bad;

  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q > LastWordAddr);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (bus.branch_taken) begin
      // Redirect wins over fault and stall, and is the only way out of HALT
      pc_d    = bus.branch_target;
      flush   = 1'b1;
      fault_d = 1'b0;
      state_d = StRun;
    end else begin
      case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (pc_bad) begin
            flush   = 1'b1;
            fault_d = 1'b1;
            state_d = StHalt;
          end else if (!bus.stall) begin
            pc_d = pc_q + XLEN'(4);
            load = 1'b1;
          end
        end
        StHalt:  flush = 1'b1;
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (flush),
    .pc_i    (pc_q),
    .instr_i (bus.imem_instr),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_id_pc;
  assign bus.if_id_instr = if_id_instr;
  assign bus.if_id_valid = if_id_valid;
  assign bus.fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= count_q + XLEN'(1);
    end
  end

  assign bus.fetch_count = count_q;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 4096, meaning the instruction memory size in bytes, used for range checks.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: downstream hold request.
REQ-006 SHALL have port branch_taken, input, 1 bit: redirect request from execute.
REQ-007 SHALL have port branch_target, input, 64 bits: redirect PC.
REQ-008 SHALL have port imem_addr, output, 64 bits: byte address to instruction memory.
REQ-009 SHALL have port imem_instr, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-010 SHALL have ports if_id_pc (output, 64 bits), if_id_instr (output, 32 bits) and if_id_valid (output, 1 bit): the IF/ID pipeline register.
REQ-011 SHALL have port fetch_fault, output, 1 bit: misaligned or out-of-range PC flag.
REQ-012 SHALL have port fetch_count, output, 64 bits: valid fetches counter (see Configuration).

Function
REQ-013 SHALL drive imem_addr = pc combinationally, with zero added latency.
REQ-014 SHALL have FSM states BOOT, RUN and HALT.
REQ-015 BOOT lasts exactly one cycle after reset: if_id_valid=0, pc held, then BOOT->RUN.
REQ-016 In RUN with no stall and no redirect: pc <= pc+4 (mod 2^64 wrap); if_id_instr <= imem_instr; if_id_pc <= pc; if_id_valid <= 1.
REQ-017 On stall in RUN: pc and all if_id_* registers hold unchanged.
REQ-018 Priority SHALL be reset > branch_taken > fault > stall.
REQ-019 branch_taken in any state: pc <= branch_target; if_id_instr <= NOP (32'h00000013); if_id_valid <= 0; next state RUN. Redirect applies even while stall is high.
REQ-020 Fault condition: pc[1:0]!=0 or pc > IMEM_SIZE-4.
REQ-021 On fault in RUN: no fetch issued; if_id_valid <= 0; if_id_instr <= NOP; pc held; fetch_fault <= 1 (registered, sticky); next state HALT.
REQ-022 HALT SHALL hold pc with if_id_valid=0; exit only via branch_taken, which also clears fetch_fault, or via reset.
REQ-023 Latency: instruction at PC p SHALL appear on if_id_* one cycle after imem_addr=p (1-cycle fetch).

Reset
REQ-024 Reset SHALL be synchronous and active-high, taking precedence over all inputs, including mid-stall and mid-HALT.
REQ-025 Reset values SHALL be: pc=RESET_PC, state=BOOT, if_id_pc=0, if_id_instr=NOP, if_id_valid=0, fetch_fault=0, fetch_count=0.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN: when defined, fetch_count SHALL increment by 1 on every cycle that loads if_id_valid<=1, wrapping at 2^64.
REQ-027 When FETCH_PERF_CNT_EN is undefined, fetch_count SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-028 Shared package riscv_pkg SHALL hold: NOP_INSTR constant, IMEM_SIZE default, the fetch FSM state enum, and the XLEN=64 constant.
REQ-029 Sub-module if_id_reg SHALL hold the IF/ID register (load, hold, flush-to-NOP controls); PC and FSM logic stay in fetch_stage.

Verification
REQ-030 Reset with RESET_PC=0, then 4 free cycles: imem_addr SHALL read 0,0,4,8; if_id_valid SHALL be 0 in the BOOT cycle, then 1 with if_id_pc=0,4.
REQ-031 stall high 3 cycles at pc=0x10: imem_addr, if_id_pc and if_id_instr SHALL be stable for those 3 cycles; fetching SHALL resume at 0x14.
REQ-032 branch_taken with target 0x40 while stall is high: next cycle pc=0x40 and if_id_valid=0 with instr 0x00000013; following cycle if_id_pc=0x40.
REQ-033 branch_target 0x42: fetch_fault=1, state HALT, if_id_valid=0 for 5 cycles; then branch to 0x80: fetch_fault=0 and fetching SHALL resume.
REQ-034 Sequential run to pc=4092 with IMEM_SIZE=4096: the word at 4092 is fetched; pc=4096 SHALL fault, and fetch_count SHALL equal 1024 (FETCH_PERF_CNT_EN) or 0 (undefined).
REQ-035 Reset asserted in HALT with stall high: next cycle SHALL show all reset values and state BOOT.
